// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding and
// the bundle of pipeline-register controls, with canned control patterns.
package pipe_ctrl_pkg;

  localparam int unsigned CTRL_ST_W = 2;
  // Width of the bubble / extra-flush counter; LD_STALL_CYC and BR_EXTRA are at most 3.
  localparam int unsigned BUB_W     = 2;

  typedef enum logic [CTRL_ST_W-1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic memwb_bubble;
  } ctrl_out_t;

  // Everything advances, nothing is squashed.
  function automatic ctrl_out_t ctrl_default();
    ctrl_out_t o;
    o.pc_we        = 1'b1;
    o.ifid_we      = 1'b1;
    o.ifid_flush   = 1'b0;
    o.idex_we      = 1'b1;
    o.idex_flush   = 1'b0;
    o.exmem_we     = 1'b1;
    o.memwb_bubble = 1'b0;
    return o;
  endfunction

  // Held in reset: nothing loads, every stage sees a NOP.
  function automatic ctrl_out_t ctrl_reset();
    ctrl_out_t o;
    o.pc_we        = 1'b0;
    o.ifid_we      = 1'b0;
    o.ifid_flush   = 1'b1;
    o.idex_we      = 1'b0;
    o.idex_flush   = 1'b1;
    o.exmem_we     = 1'b0;
    o.memwb_bubble = 1'b1;
    return o;
  endfunction

  // Memory not ready: whole front of the pipe holds, WB receives a bubble.
  function automatic ctrl_out_t ctrl_freeze();
    ctrl_out_t o;
    o = ctrl_default();
    o.pc_we        = 1'b0;
    o.ifid_we      = 1'b0;
    o.idex_we      = 1'b0;
    o.exmem_we     = 1'b0;
    o.memwb_bubble = 1'b1;
    return o;
  endfunction

  // Load-use: hold PC and IF/ID, inject a bubble into ID/EX.
  function automatic ctrl_out_t ctrl_ld_stall();
    ctrl_out_t o;
    o = ctrl_default();
    o.pc_we      = 1'b0;
    o.ifid_we    = 1'b0;
    o.idex_flush = 1'b1;
    return o;
  endfunction

  // Taken branch resolved in EX: load target, squash the two younger stages.
  function automatic ctrl_out_t ctrl_branch();
    ctrl_out_t o;
    o = ctrl_default();
    o.ifid_flush = 1'b1;
    o.idex_flush = 1'b1;
    return o;
  endfunction

  // Extra post-branch bubble: keep squashing what fetch delivers.
  function automatic ctrl_out_t ctrl_br_extra();
    ctrl_out_t o;
    o = ctrl_default();
    o.ifid_flush = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  // Count events, stick at all-ones, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != CntMax)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Merges load-use hazards,
// EX-stage taken branches and the data-memory handshake into write enables and
// flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Outputs are Mealy.
// Optional perf counters are built when PIPE_STALL_PERF_EN is defined;
// otherwise the counter outputs read as zero.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LD_STALL_CYC = 1,
  parameter int unsigned BR_EXTRA     = 0,
  parameter int unsigned MEM_WAIT_MAX = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 ifid_flush,
  output logic                 idex_we,
  output logic                 idex_flush,
  output logic                 exmem_we,
  output logic                 memwb_bubble,
  output logic [CTRL_ST_W-1:0] ctrl_state,
  output logic                 mem_timeout,
  input  logic                 perf_clr,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events,
  output logic [CNT_W-1:0]     mem_wait_cycles
);

  localparam logic [BUB_W-1:0] LdCyc   = BUB_W'(LD_STALL_CYC);
  localparam logic [BUB_W-1:0] BrExtra = BUB_W'(BR_EXTRA);
  localparam logic [CNT_W-1:0] WaitMax = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] WaitSat = {CNT_W{1'b1}};

  ctrl_state_t      r_state,     w_state_d;
  logic [BUB_W-1:0] r_bub,       w_bub_d;
  ctrl_state_t      r_ret_state, w_ret_state_d;
  logic [BUB_W-1:0] r_ret_bub,   w_ret_bub_d;
  logic [CNT_W-1:0] r_wait_cnt,  w_wait_cnt_d;
  logic             r_timeout,   w_timeout_d;

  ctrl_out_t w_ctrl;
  logic      w_mem_stall;
  logic      w_stall_ev;
  logic      w_flush_ev;
  logic      w_wait_ev;

  assign w_mem_stall = mem_req & ~mem_ready;
  assign w_wait_ev   = (r_state == MEM_WAIT);

  // State, bubble counter, saved context and sticky timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_bub       <= '0;
      r_ret_state <= RUN;
      r_ret_bub   <= '0;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_bub       <= w_bub_d;
      r_ret_state <= w_ret_state_d;
      r_ret_bub   <= w_ret_bub_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_timeout   <= w_timeout_d;
    end
  end

  // Next state and Mealy controls; priority is memory wait > branch > hazard.
  always_comb begin
    w_ctrl        = ctrl_default();
    w_state_d     = r_state;
    w_bub_d       = r_bub;
    w_ret_state_d = r_ret_state;
    w_ret_bub_d   = r_ret_bub;
    w_wait_cnt_d  = r_wait_cnt;
    w_stall_ev    = 1'b0;
    w_flush_ev    = 1'b0;

    if (r_state == MEM_WAIT) begin
      // EX/ID are frozen here, so branch/hazard will be re-presented after return.
      if (mem_ready) begin
        w_state_d = r_ret_state;
        w_bub_d   = r_ret_bub;
      end else begin
        w_ctrl = ctrl_freeze();
        if (r_wait_cnt != WaitSat) begin
          w_wait_cnt_d = r_wait_cnt + 1'b1;
        end
      end
    end else if (w_mem_stall) begin
      w_ctrl        = ctrl_freeze();
      w_ret_state_d = r_state;
      w_ret_bub_d   = r_bub;
      w_state_d     = MEM_WAIT;
      w_wait_cnt_d  = CNT_W'(1);
    end else if (branch_taken) begin
      // Also abandons any load-use stall in progress.
      w_ctrl     = ctrl_branch();
      w_flush_ev = 1'b1;
      if (BR_EXTRA == 0) begin
        w_state_d = RUN;
        w_bub_d   = '0;
      end else begin
        w_state_d = BR_FLUSH;
        w_bub_d   = BUB_W'(1);
      end
    end else begin
      unique case (r_state)
        RUN: begin
          if (hazard_detected) begin
            w_ctrl     = ctrl_ld_stall();
            w_stall_ev = 1'b1;
            w_state_d  = LD_STALL;
            w_bub_d    = BUB_W'(1);
          end
        end
        LD_STALL: begin
          if (r_bub < LdCyc) begin
            w_ctrl     = ctrl_ld_stall();
            w_stall_ev = 1'b1;
            w_bub_d    = r_bub + 1'b1;
          end else begin
            // Release cycle: the stalled instruction issues, hazard is stale.
            w_state_d = RUN;
            w_bub_d   = '0;
          end
        end
        BR_FLUSH: begin
          w_ctrl = ctrl_br_extra();
          if (r_bub < BrExtra) begin
            w_bub_d = r_bub + 1'b1;
          end else begin
            w_state_d = RUN;
            w_bub_d   = '0;
          end
        end
        default: begin
          w_state_d = RUN;
          w_bub_d   = '0;
        end
      endcase
    end

    w_timeout_d = r_timeout | ((w_state_d == MEM_WAIT) && (w_wait_cnt_d == WaitMax));
  end

  // Drive pipeline controls; reset overrides asynchronously.
  always_comb begin
    if (!rst_n) begin
      {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble} = ctrl_reset();
    end else begin
      {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble} = w_ctrl;
    end
  end

  assign ctrl_state  = r_state;
  assign mem_timeout = r_timeout;

`ifdef PIPE_STALL_PERF_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (w_stall_ev),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (w_flush_ev),
    .count (flush_events)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (w_wait_ev),
    .count (mem_wait_cycles)
  );
`else
  logic w_unused_perf;
  assign w_unused_perf   = perf_clr ^ w_stall_ev ^ w_flush_ev ^ w_wait_ev;
  assign stall_cycles    = '0;
  assign flush_events    = '0;
  assign mem_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: two configurations driven in lockstep and
// checked every cycle against a bubble/flush bookkeeping model, plus literal
// expectations for the key scenarios.
module tb_pipeline_stall_ctrl;

`ifdef PIPE_STALL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam bit [6:0] O_DEF   = 7'b1101010;
  localparam bit [6:0] O_RST   = 7'b0010101;
  localparam bit [6:0] O_FRZ   = 7'b0000001;
  localparam bit [6:0] O_STALL = 7'b0001110;
  localparam bit [6:0] O_BR    = 7'b1111110;
  localparam bit [6:0] O_BRX   = 7'b1111010;

  logic clk = 1'b0;
  logic rst_n, hazard, branch, mreq, mready, pclr;

  logic [6:0]  a_o, b_o;
  logic [1:0]  a_st, b_st;
  logic        a_to, b_to;
  logic [15:0] a_stall, a_flush, a_wait;
  logic [3:0]  b_stall, b_flush, b_wait;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.LD_STALL_CYC(1), .BR_EXTRA(0), .MEM_WAIT_MAX(4), .CNT_W(16)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .hazard_detected (hazard), .branch_taken (branch),
    .mem_req (mreq), .mem_ready (mready),
    .pc_we (a_o[6]), .ifid_we (a_o[5]), .ifid_flush (a_o[4]), .idex_we (a_o[3]),
    .idex_flush (a_o[2]), .exmem_we (a_o[1]), .memwb_bubble (a_o[0]),
    .ctrl_state (a_st), .mem_timeout (a_to), .perf_clr (pclr),
    .stall_cycles (a_stall), .flush_events (a_flush), .mem_wait_cycles (a_wait)
  );

  pipeline_stall_ctrl #(.LD_STALL_CYC(2), .BR_EXTRA(2), .MEM_WAIT_MAX(6), .CNT_W(4)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .hazard_detected (hazard), .branch_taken (branch),
    .mem_req (mreq), .mem_ready (mready),
    .pc_we (b_o[6]), .ifid_we (b_o[5]), .ifid_flush (b_o[4]), .idex_we (b_o[3]),
    .idex_flush (b_o[2]), .exmem_we (b_o[1]), .memwb_bubble (b_o[0]),
    .ctrl_state (b_st), .mem_timeout (b_to), .perf_clr (pclr),
    .stall_cycles (b_stall), .flush_events (b_flush), .mem_wait_cycles (b_wait)
  );

  // Model: tracks bubbles issued, extra flushes owed and wait length directly.
  typedef struct packed {
    int ld_cyc; int br_extra; int wait_max; int cnt_max;
    bit waiting; bit timeout;
    int wait_len; int ld_done; int br_left; int sv_ld; int sv_br;
    int c_stall; int c_flush; int c_wait;
  } mdl_t;

  typedef struct packed {
    bit [6:0] o; bit [1:0] st; bit to; int stall; int flush; int waitc;
  } exp_t;

  function automatic mdl_t mdl_init(input int ld, input int br, input int mx, input int cw);
    mdl_t m;
    m = '0;
    m.ld_cyc = ld; m.br_extra = br; m.wait_max = mx; m.cnt_max = (1 << cw) - 1;
    return m;
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  function automatic void mstep(input mdl_t mi, input bit hz, input bit br, input bit rq,
                                input bit rd, input bit cl, output exp_t e, output mdl_t mo);
    mo = mi;
    e.o     = O_DEF;
    e.st    = mi.waiting ? 2'd3 : (mi.br_left > 0) ? 2'd2 : (mi.ld_done > 0) ? 2'd1 : 2'd0;
    e.to    = mi.timeout;
    e.stall = mi.c_stall;
    e.flush = mi.c_flush;
    e.waitc = mi.c_wait;
    if (mi.waiting) begin
      mo.c_wait = sat_inc(mi.c_wait, mi.cnt_max);
      if (rd) begin
        mo.waiting = 1'b0;
        mo.ld_done = mi.sv_ld;
        mo.br_left = mi.sv_br;
      end else begin
        e.o = O_FRZ;
        mo.wait_len = sat_inc(mi.wait_len, mi.cnt_max);
        if (mo.wait_len == mi.wait_max) mo.timeout = 1'b1;
      end
    end else if (rq && !rd) begin
      e.o = O_FRZ;
      mo.waiting = 1'b1;
      mo.sv_ld = mi.ld_done;
      mo.sv_br = mi.br_left;
      mo.wait_len = 1;
      if (mi.wait_max == 1) mo.timeout = 1'b1;
    end else if (br) begin
      e.o = O_BR;
      mo.c_flush = sat_inc(mi.c_flush, mi.cnt_max);
      mo.ld_done = 0;
      mo.br_left = mi.br_extra;
    end else if (mi.br_left > 0) begin
      e.o = O_BRX;
      mo.br_left = mi.br_left - 1;
    end else if (mi.ld_done > 0) begin
      if (mi.ld_done < mi.ld_cyc) begin
        e.o = O_STALL;
        mo.ld_done = mi.ld_done + 1;
        mo.c_stall = sat_inc(mi.c_stall, mi.cnt_max);
      end else begin
        mo.ld_done = 0;
      end
    end else if (hz) begin
      e.o = O_STALL;
      mo.ld_done = 1;
      mo.c_stall = sat_inc(mi.c_stall, mi.cnt_max);
    end
    if (cl) begin
      mo.c_stall = 0; mo.c_flush = 0; mo.c_wait = 0;
    end
  endfunction

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  bit        lit_a_en, lit_b_en, lit_c_en;
  string     lit_a_nm, lit_b_nm, lit_c_nm;
  bit [9:0]  lit_a_v, lit_b_v;
  bit        lit_c_dut;
  int        lit_c_sel, lit_c_val;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 'h%0h, want 'h%0h", nm, cyc, act, exp);
  endtask

  function automatic int cnt_of(input bit dut, input int sel);
    if (!dut) return (sel == 1) ? int'(a_stall) : (sel == 2) ? int'(a_flush) : int'(a_wait);
    return (sel == 1) ? int'(b_stall) : (sel == 2) ? int'(b_flush) : int'(b_wait);
  endfunction

  // Compare process: every negedge, DUT outputs versus model and literals.
  initial begin
    mdl_t ma, mb, na, nb;
    exp_t ea, eb;
    ma = mdl_init(1, 0, 4, 16);
    mb = mdl_init(2, 2, 6, 4);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ma = mdl_init(1, 0, 4, 16);
        mb = mdl_init(2, 2, 6, 4);
        ea = '0; ea.o = O_RST;
        eb = ea;
      end else begin
        mstep(ma, hazard, branch, mreq, mready, pclr, ea, na);
        mstep(mb, hazard, branch, mreq, mready, pclr, eb, nb);
        ma = na;
        mb = nb;
      end
      chk("A.ctrl",  int'({a_o, a_st, a_to}), int'({ea.o, ea.st, ea.to}));
      chk("A.stall", int'(a_stall), PerfEn ? ea.stall : 0);
      chk("A.flush", int'(a_flush), PerfEn ? ea.flush : 0);
      chk("A.wait",  int'(a_wait),  PerfEn ? ea.waitc : 0);
      chk("B.ctrl",  int'({b_o, b_st, b_to}), int'({eb.o, eb.st, eb.to}));
      chk("B.stall", int'(b_stall), PerfEn ? eb.stall : 0);
      chk("B.flush", int'(b_flush), PerfEn ? eb.flush : 0);
      chk("B.wait",  int'(b_wait),  PerfEn ? eb.waitc : 0);
      if (lit_a_en) chk(lit_a_nm, int'({a_o, a_st, a_to}), int'(lit_a_v));
      if (lit_b_en) chk(lit_b_nm, int'({b_o, b_st, b_to}), int'(lit_b_v));
      if (lit_c_en) chk(lit_c_nm, cnt_of(lit_c_dut, lit_c_sel), PerfEn ? lit_c_val : 0);
      cyc++;
    end
  end

  task automatic drive(input bit r, input bit hz, input bit br, input bit rq, input bit rd,
                       input bit cl);
    @(posedge clk);
    #1;
    rst_n = r; hazard = hz; branch = br; mreq = rq; mready = rd; pclr = cl;
    lit_a_en = 1'b0; lit_b_en = 1'b0; lit_c_en = 1'b0;
  endtask

  task automatic lit_a(input string nm, input bit [6:0] o, input bit [1:0] st, input bit to);
    lit_a_en = 1'b1; lit_a_nm = nm; lit_a_v = {o, st, to};
  endtask

  task automatic lit_b(input string nm, input bit [6:0] o, input bit [1:0] st, input bit to);
    lit_b_en = 1'b1; lit_b_nm = nm; lit_b_v = {o, st, to};
  endtask

  task automatic lit_c(input string nm, input bit dut, input int sel, input int val);
    lit_c_en = 1'b1; lit_c_nm = nm; lit_c_dut = dut; lit_c_sel = sel; lit_c_val = val;
  endtask

  initial begin
    rst_n = 1'b0; hazard = 1'b0; branch = 1'b0; mreq = 1'b0; mready = 1'b0; pclr = 1'b0;
    lit_a_en = 1'b0; lit_b_en = 1'b0; lit_c_en = 1'b0;
    lit_c_dut = 1'b0; lit_c_sel = 1; lit_c_val = 0;

    drive(0, 0, 0, 0, 0, 0); lit_a("rst_forced", O_RST, 2'd0, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); lit_a("idle_run", O_DEF, 2'd0, 1'b0);

    // Load-use: A releases after one bubble, B after two.
    drive(1, 1, 0, 0, 0, 0); lit_a("lu_c0", O_STALL, 2'd0, 1'b0);
                             lit_b("lu_b_c0", O_STALL, 2'd0, 1'b0);
    drive(1, 1, 0, 0, 0, 0); lit_a("lu_c1", O_DEF, 2'd1, 1'b0);
                             lit_b("lu_b_c1", O_STALL, 2'd1, 1'b0);
    drive(1, 0, 0, 0, 0, 0); lit_a("lu_after", O_DEF, 2'd0, 1'b0);
                             lit_b("lu_b_rel", O_DEF, 2'd1, 1'b0);
                             lit_c("stall_a", 0, 1, 1);
    drive(1, 0, 0, 0, 0, 0); lit_c("stall_b", 1, 1, 2);

    // Branch with hazard: branch wins, no stall.
    drive(1, 1, 1, 0, 0, 0); lit_a("br_hz", O_BR, 2'd0, 1'b0);
                             lit_b("br_hz_b", O_BR, 2'd0, 1'b0);
    drive(1, 0, 0, 0, 0, 0); lit_a("br_hz_next", O_DEF, 2'd0, 1'b0);
                             lit_b("br_extra1", O_BRX, 2'd2, 1'b0);
    drive(1, 0, 0, 0, 0, 0); lit_b("br_extra2", O_BRX, 2'd2, 1'b0);
                             lit_c("flush_a", 0, 2, 1);
    drive(1, 0, 0, 0, 0, 0); lit_b("br_done", O_DEF, 2'd0, 1'b0);

    // Memory wait entered from LD_STALL, five frozen cycles; A times out.
    drive(1, 1, 0, 0, 0, 0); lit_b("mw_pre", O_STALL, 2'd0, 1'b0);
    drive(1, 1, 0, 1, 0, 0); lit_b("mw_entry", O_FRZ, 2'd1, 1'b0);
                             lit_a("mw_entry_a", O_FRZ, 2'd1, 1'b0);
    drive(1, 1, 0, 1, 0, 0); lit_a("to_wc1", O_FRZ, 2'd3, 1'b0);
                             lit_b("mw_2", O_FRZ, 2'd3, 1'b0);
    drive(1, 1, 0, 1, 0, 0);
    drive(1, 1, 0, 1, 0, 0); lit_a("to_wc3", O_FRZ, 2'd3, 1'b0);
    drive(1, 1, 0, 1, 0, 0); lit_a("to_rise", O_FRZ, 2'd3, 1'b1);
                             lit_b("mw_5th", O_FRZ, 2'd3, 1'b0);
    drive(1, 1, 0, 1, 1, 0); lit_b("mw_ready", O_DEF, 2'd3, 1'b0);
                             lit_a("mw_ready_a", O_DEF, 2'd3, 1'b1);
    drive(1, 1, 0, 0, 0, 0); lit_b("mw_resume", O_STALL, 2'd1, 1'b0);
                             lit_a("to_sticky", O_DEF, 2'd1, 1'b1);
    drive(1, 0, 0, 0, 0, 0); lit_b("mw_release", O_DEF, 2'd1, 1'b0);
                             lit_c("wait_b", 1, 3, 5);
    drive(1, 0, 0, 0, 0, 0); lit_c("wait_a", 0, 3, 5);

    // Reset dropped while waiting on memory.
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    #2 rst_n = 1'b0;         lit_a("rst_async", O_RST, 2'd0, 1'b0);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0); lit_a("post_rst", O_DEF, 2'd0, 1'b0);
                             lit_c("rst_wait_clr", 0, 3, 0);

    // Perf clear coincident with a flush.
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); lit_c("flush_pre", 0, 2, 1);
    drive(1, 0, 1, 0, 0, 1); lit_a("br_clr", O_BR, 2'd0, 1'b0);
    drive(1, 0, 0, 0, 0, 0); lit_c("perf_clr", 0, 2, 0);

    // Back-to-back branches saturate B's 4-bit counter.
    for (int i = 0; i < 17; i++) drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); lit_c("flush_sat_b", 1, 2, 15);
    drive(1, 0, 0, 0, 0, 0); lit_c("flush_a17", 0, 2, 17);

    // Branch during LD_STALL abandons the stall.
    drive(1, 1, 0, 0, 0, 0); lit_b("ld_pre_br", O_STALL, 2'd0, 1'b0);
    drive(1, 0, 1, 0, 0, 0); lit_b("ld_br", O_BR, 2'd1, 1'b0);
    drive(1, 0, 0, 0, 0, 0); lit_b("ld_br_extra", O_BRX, 2'd2, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
